swervolf_sseg_scan: RTL and testbench

- Downstream display stage for the Nexys A7 toplevel. Takes a 32-bit value from core-side status logic, such as branch statistics counters, and time-multiplexes it as 8 hex digits onto the board's common-anode seven-segment display.
- The displayed value updates only at frame boundaries, so a frame never mixes digits from two values.
- Anodes go dark for a short period at each digit change to suppress ghosting.

---
 rtl/swervolf_sseg_pkg.sv | 35 +++
 rtl/swervolf_sseg_tick.sv | 30 +++
 rtl/swervolf_sseg_scan.sv | 120 ++++++++++++
 tb/tb_swervolf_sseg_scan.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/swervolf_sseg_pkg.sv
// Shared definitions for the seven-segment scanner: digit count,
// segment type and the active-low hex-to-segment decode table.
package swervolf_sseg_pkg;

  localparam int NUM_DIGITS = 8;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_BLANK = 7'h7F;

  // Segment order is {a,b,c,d,e,f,g}; a lit segment is driven low.
  function automatic seg_t hex_to_seg(input logic [3:0] nib);
    seg_t seg;
    case (nib)
      4'h0:    seg = 7'b0000001;
      4'h1:    seg = 7'b1001111;
      4'h2:    seg = 7'b0010010;
      4'h3:    seg = 7'b0000110;
      4'h4:    seg = 7'b1001100;
      4'h5:    seg = 7'b0100100;
      4'h6:    seg = 7'b0100000;
      4'h7:    seg = 7'b0001111;
      4'h8:    seg = 7'b0000000;
      4'h9:    seg = 7'b0000100;
      4'hA:    seg = 7'b0001000;
      4'hB:    seg = 7'b1100000;
      4'hC:    seg = 7'b0110001;
      4'hD:    seg = 7'b1000010;
      4'hE:    seg = 7'b0110000;
      default: seg = 7'b0111000;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/swervolf_sseg_tick.sv
// Digit-slot prescaler: cnt runs 0..DIGIT_CYCLES-1 and tick marks the
// last cycle of each slot.
module swervolf_sseg_tick #(
  parameter int DIGIT_CYCLES = 50000,
  localparam int CW = $clog2(DIGIT_CYCLES)
) (
  input  logic          clk,
  input  logic          rstn,
  output logic [CW-1:0] cnt,
  output logic          tick
);

  localparam logic [CW-1:0] CNT_LAST = CW'(DIGIT_CYCLES - 1);

  logic [CW-1:0] cnt_reg;

  assign tick = (cnt_reg == CNT_LAST);
  assign cnt  = cnt_reg;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_reg <= '0;
    end else if (tick) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + CW'(1);
    end
  end

endmodule

// File: rtl/swervolf_sseg_scan.sv
// Time-multiplexed 8-digit hex driver for a common-anode display with
// frame-synchronous value update. Define SWERVOLF_SSEG_LZ_BLANK_EN for leading-zero blanking.
module swervolf_sseg_scan
  import swervolf_sseg_pkg::*;
#(
  parameter int DIGIT_CYCLES = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] i_value,
  input  logic [7:0]  i_dp,
  input  logic        i_load,
  output logic        o_pending,
  output logic        o_frame,
  output logic [7:0]  o_an,
  output logic [6:0]  o_seg,
  output logic        o_dp
);

  localparam int CW = $clog2(DIGIT_CYCLES);
  localparam logic [CW-1:0] BLANK_CNT = CW'(BLANK_CYCLES);

  logic [CW-1:0] cnt;
  logic          tick;

  swervolf_sseg_tick #(
    .DIGIT_CYCLES(DIGIT_CYCLES)
  ) u_tick (
    .clk  (clk),
    .rstn (rstn),
    .cnt  (cnt),
    .tick (tick)
  );

  logic [2:0]            idx_reg;
  logic [31:0]           disp_reg;
  logic [31:0]           pend_reg;
  logic [7:0]            disp_dp_reg;
  logic [7:0]            pend_dp_reg;
  logic                  pending_reg;
  logic                  frame_reg;
  logic [7:0]            an_reg;
  seg_t                  seg_reg;
  logic                  dp_reg;

  logic                  boundary;
  logic                  lit;
  logic [3:0]            nib [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] lz_blank;
  logic [7:0]            an_next;
  seg_t                  seg_next;

  assign boundary = tick && (idx_reg == 3'd7);
  assign lit      = (BLANK_CYCLES == 0) || (cnt >= BLANK_CNT);

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_nib
    assign nib[gi] = disp_reg[4*gi +: 4];
  end

`ifdef SWERVOLF_SSEG_LZ_BLANK_EN
  // Digit k is blank when every nibble from k upward is zero; digit 0 always shows.
  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_lz
    if (gi == 0) begin : g_first
      assign lz_blank[gi] = 1'b0;
    end else begin : g_upper
      assign lz_blank[gi] = ~|disp_reg[4*NUM_DIGITS-1 : 4*gi];
    end
  end
`else
  assign lz_blank = '0;
`endif

  assign an_next  = lit ? ~(8'b1 << idx_reg) : 8'hFF;
  assign seg_next = lz_blank[idx_reg] ? SEG_BLANK : hex_to_seg(nib[idx_reg]);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      idx_reg     <= '0;
      disp_reg    <= '0;
      pend_reg    <= '0;
      disp_dp_reg <= '0;
      pend_dp_reg <= '0;
      pending_reg <= 1'b0;
      frame_reg   <= 1'b0;
      an_reg      <= 8'hFF;
      seg_reg     <= SEG_BLANK;
      dp_reg      <= 1'b1;
    end else begin
      if (tick) begin
        idx_reg <= idx_reg + 3'd1;
      end
      frame_reg <= boundary;

      // A load on the boundary cycle lands in pend after the old pend moved to disp.
      if (boundary && pending_reg) begin
        disp_reg    <= pend_reg;
        disp_dp_reg <= pend_dp_reg;
      end
      if (i_load) begin
        pend_reg    <= i_value;
        pend_dp_reg <= i_dp;
        pending_reg <= 1'b1;
      end else if (boundary) begin
        pending_reg <= 1'b0;
      end

      an_reg  <= an_next;
      seg_reg <= seg_next;
      dp_reg  <= ~disp_dp_reg[idx_reg];
    end
  end

  assign o_pending = pending_reg;
  assign o_frame   = frame_reg;
  assign o_an      = an_reg;
  assign o_seg     = seg_reg;
  assign o_dp      = dp_reg;

endmodule

// File: tb/tb_swervolf_sseg_scan.sv
// Directed bench for swervolf_sseg_scan with DIGIT_CYCLES=8, BLANK_CYCLES=2.
// Sampling and driving both happen on the falling edge; k counts rising edges since reset release.
module tb_swervolf_sseg_scan;

  logic        clk;
  logic        rstn;
  logic [31:0] i_value;
  logic [7:0]  i_dp;
  logic        i_load;
  logic        o_pending;
  logic        o_frame;
  logic [7:0]  o_an;
  logic [6:0]  o_seg;
  logic        o_dp;

  int check_cnt;
  int pass_cnt;
  int k;

  swervolf_sseg_scan #(
    .DIGIT_CYCLES(8),
    .BLANK_CYCLES(2)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .i_value   (i_value),
    .i_dp      (i_dp),
    .i_load    (i_load),
    .o_pending (o_pending),
    .o_frame   (o_frame),
    .o_an      (o_an),
    .o_seg     (o_seg),
    .o_dp      (o_dp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_cnt++;
    if (obs !== exp) begin
      $display("FAIL %s: got %0h, expected %0h (k=%0d)", tag, obs, exp, k);
    end else begin
      pass_cnt++;
      $display("ok   %s: %0h (k=%0d)", tag, obs, k);
    end
  endtask

  task automatic step_to(input int target);
    while (k < target) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic load_value(input logic [31:0] val, input logic [7:0] dp);
    i_value = val;
    i_dp    = dp;
    i_load  = 1'b1;
    @(negedge clk);
    k++;
    i_load  = 1'b0;
  endtask

  task automatic release_reset();
    @(negedge clk);
    rstn = 1'b1;
    k    = 0;
  endtask

  // Hard stop in case the run ever stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int frames;
    int prev_frame;
    int multi_low;
    int an_low [8];
    logic [7:0] an_l;

    check_cnt = 0;
    pass_cnt  = 0;
    k         = 0;
    rstn      = 1'b0;
    i_value   = '0;
    i_dp      = '0;
    i_load    = 1'b0;

    repeat (3) @(negedge clk);
    check_value("rst_an", o_an, 8'hFF);
    check_value("rst_seg", o_seg, 7'h7F);
    check_value("rst_dp", o_dp, 1'b1);
    check_value("rst_pending", o_pending, 1'b0);
    check_value("rst_frame", o_frame, 1'b0);

    // Release: two blank cycles, then digit 0 lit for six cycles.
    release_reset();
    step_to(2);
    check_value("rel_an_blank", o_an, 8'hFF);
    step_to(3);
    check_value("rel_an_d0", o_an, 8'hFE);
    check_value("rel_seg_d0", o_seg, 7'b0000001);
    check_value("rel_dp_d0", o_dp, 1'b1);
    step_to(8);
    check_value("rel_an_d0_last", o_an, 8'hFE);
    step_to(10);
    check_value("rel_an_d1_blank", o_an, 8'hFF);
    step_to(11);
    check_value("rel_an_d1", o_an, 8'hFD);
    check_value("rel_seg_d1", o_seg, 7'b0000001);

    // Load at idx 3; the displayed value must not change until the boundary.
    step_to(25);
    load_value(32'h89AB_CDEF, 8'h01);
    check_value("ld_pending", o_pending, 1'b1);
    step_to(35);
    check_value("ld_an_d4", o_an, 8'hEF);
    check_value("ld_seg_d4_old", o_seg, 7'b0000001);
    step_to(63);
    check_value("ld_frame_before", o_frame, 1'b0);
    step_to(64);
    check_value("ld_frame_pulse", o_frame, 1'b1);
    check_value("ld_pending_clr", o_pending, 1'b0);
    step_to(65);
    check_value("ld_frame_once", o_frame, 1'b0);
    check_value("ld_seg_d0", o_seg, 7'b0111000);
    check_value("ld_dp_d0", o_dp, 1'b0);
    step_to(125);
    check_value("ld_an_d7", o_an, 8'h7F);
    check_value("ld_seg_d7", o_seg, 7'b0000000);
    check_value("ld_dp_d7", o_dp, 1'b1);
    step_to(93);
    step_to(128);
    check_value("run_frame_start", o_frame, 1'b1);

    // Free-run three frames.
    frames     = 0;
    prev_frame = 128;
    multi_low  = 0;
    for (int i = 0; i < 8; i++) an_low[i] = 0;
    for (int n = 0; n < 192; n++) begin
      step_to(k + 1);
      an_l = ~o_an;
      if (o_frame) begin
        frames++;
        check_value("run_frame_period", k - prev_frame, 64);
        prev_frame = k;
      end
      for (int i = 0; i < 8; i++) if (an_l[i]) an_low[i]++;
      if ($countones(an_l) > 1) multi_low++;
    end
    check_value("run_frames", frames, 3);
    for (int i = 0; i < 8; i++) check_value($sformatf("run_an%0d_low", i), an_low[i], 18);
    check_value("run_multi_low", multi_low, 0);

    // Load coinciding with a boundary while another value is pending.
    step_to(330);
    load_value(32'h2222_2222, 8'h00);
    step_to(383);
    load_value(32'h1111_1111, 8'h00);
    check_value("co_frame", o_frame, 1'b1);
    check_value("co_pending_kept", o_pending, 1'b1);
    step_to(387);
    check_value("co_seg_d0_two", o_seg, 7'b0010010);
    check_value("co_dp_d0", o_dp, 1'b1);
    step_to(427);
    check_value("co_seg_d5_two", o_seg, 7'b0010010);
    step_to(448);
    check_value("co_pending_clr", o_pending, 1'b0);
    step_to(451);
    check_value("co_seg_d0_one", o_seg, 7'b1001111);

    // Reset mid-slot at idx 5 with a load pending.
    step_to(460);
    load_value(32'h5555_5555, 8'hFF);
    step_to(492);
    check_value("mr_an_d5", o_an, 8'hDF);
    check_value("mr_pending", o_pending, 1'b1);
    rstn = 1'b0;
    #1;
    check_value("mr_rst_an", o_an, 8'hFF);
    check_value("mr_rst_seg", o_seg, 7'h7F);
    check_value("mr_rst_dp", o_dp, 1'b1);
    check_value("mr_rst_pending", o_pending, 1'b0);
    repeat (2) @(negedge clk);
    release_reset();
    step_to(3);
    check_value("mr_rel_an_d0", o_an, 8'hFE);
    check_value("mr_rel_seg_d0", o_seg, 7'b0000001);
    check_value("mr_rel_pending", o_pending, 1'b0);
    step_to(67);
    check_value("mr_discard_seg", o_seg, 7'b0000001);
    check_value("mr_discard_dp", o_dp, 1'b1);

    // 0x00000120: leading-zero blanking affects digits 3..7 only.
    load_value(32'h0000_0120, 8'h00);
    step_to(132);
    check_value("lz_d0", o_seg, 7'b0000001);
    step_to(140);
    check_value("lz_d1", o_seg, 7'b0010010);
    step_to(148);
    check_value("lz_d2", o_seg, 7'b1001111);
    for (int d = 3; d < 8; d++) begin
      step_to(132 + 8 * d);
`ifdef SWERVOLF_SSEG_LZ_BLANK_EN
      check_value($sformatf("lz_d%0d", d), o_seg, 7'h7F);
`else
      check_value($sformatf("lz_d%0d", d), o_seg, 7'b0000001);
`endif
    end
    check_value("lz_an_d7", o_an, 8'h7F);

    // Value 0.
    step_to(195);
    load_value(32'h0, 8'h00);
    step_to(260);
    check_value("zero_d0", o_seg, 7'b0000001);
    step_to(300);
`ifdef SWERVOLF_SSEG_LZ_BLANK_EN
    check_value("zero_d5", o_seg, 7'h7F);
`else
    check_value("zero_d5", o_seg, 7'b0000001);
`endif
    check_value("zero_an_d5", o_an, 8'hDF);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
